// File: rtl/text_line_sequencer.sv
// rtl/text_line_sequencer.sv - walks a string in memory and drives a per-glyph character renderer
//
// Purpose: fetches character codes one at a time from a synchronous string
// memory and computes each glyph's screen origin from a text cursor. It
// handles line feed, right-margin wrap and bottom-margin overflow, and runs
// the renderer's enable/finished handshake for each glyph.
//
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   start                   one-cycle run request, accepted only when idle
//   base_x/base_y           text box origin, also the left margin
//   size                    screen pixels per glyph pixel
//   length                  maximum number of codes to process
//   limit_x/limit_y         inclusive right and bottom margins
//   str_addr/str_data       string memory read port (one-cycle latency)
//   char_code/char_origin_x/char_origin_y/char_size
//                           glyph parameters presented to the renderer
//   char_enable/char_finished
//                           renderer run enable and sticky completion flag
//   busy, done              run in progress, one-cycle completion pulse
//   overflow                run stopped at the bottom margin
//   chars_drawn             glyphs rendered in the current or last run
module text_line_sequencer #(
    parameter int X_W         = 9,
    parameter int Y_W         = 8,
    parameter int CHAR_W      = 7,
    parameter int SIZE_W      = 4,
    parameter int LEN_W       = 6,
    parameter int FONT_WIDTH  = 5,
    parameter int FONT_HEIGHT = 7
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [X_W-1:0]    base_x,
    input  logic [Y_W-1:0]    base_y,
    input  logic [SIZE_W-1:0] size,
    input  logic [LEN_W-1:0]  length,
    input  logic [X_W-1:0]    limit_x,
    input  logic [Y_W-1:0]    limit_y,
    output logic [LEN_W-1:0]  str_addr,
    input  logic [CHAR_W-1:0] str_data,
    output logic [CHAR_W-1:0] char_code,
    output logic [X_W-1:0]    char_origin_x,
    output logic [Y_W-1:0]    char_origin_y,
    output logic [SIZE_W-1:0] char_size,
    output logic              char_enable,
    input  logic              char_finished,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [LEN_W-1:0]  chars_drawn
);

    // Comparison sums carry one bit beyond the cursor width so that a
    // saturated cursor plus a glyph extent can never wrap.
    localparam int XS = X_W + 2;
    localparam int YS = Y_W + 2;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT, S_CHECK, S_LOAD, S_RUN, S_NEXT, S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [X_W-1:0]    base_x_q, base_x_d, limit_x_q, limit_x_d;
    logic [Y_W-1:0]    base_y_q, base_y_d, limit_y_q, limit_y_d;
    logic [LEN_W-1:0]  length_q, length_d, index_q, index_d;
    logic [LEN_W-1:0]  chars_drawn_q, chars_drawn_d;
    logic [X_W:0]      cursor_x_q, cursor_x_d;
    logic [Y_W:0]      cursor_y_q, cursor_y_d;
    logic [CHAR_W-1:0] char_code_q, char_code_d;
    logic [X_W-1:0]    origin_x_q, origin_x_d;
    logic [Y_W-1:0]    origin_y_q, origin_y_d;
    logic [SIZE_W-1:0] char_size_q, char_size_d;
    logic              char_enable_q, char_enable_d;
    logic              busy_q, busy_d, done_q, done_d, overflow_q, overflow_d;

    logic [XS-1:0] pitch_x, glyph_w;
    logic [YS-1:0] pitch_y, glyph_h;
    logic          x_over, wrap, y_over;
    logic [X_W:0]  x_chk;
    logic [Y_W:0]  y_chk;

    assign pitch_x = XS'(char_size_q) * XS'(FONT_WIDTH + 1);
    assign glyph_w = XS'(char_size_q) * XS'(FONT_WIDTH);
    assign pitch_y = YS'(char_size_q) * YS'(FONT_HEIGHT + 1);
    assign glyph_h = YS'(char_size_q) * YS'(FONT_HEIGHT);

    // Cursor advances saturate instead of wrapping, so a long run of line
    // feeds still ends up below the bottom margin.
    function automatic logic [X_W:0] x_step(input logic [X_W:0] x, input logic [XS-1:0] p);
        logic [XS-1:0] s;
        s = {1'b0, x} + p;
        return s[XS-1] ? '1 : s[X_W:0];
    endfunction

    function automatic logic [Y_W:0] y_step(input logic [Y_W:0] y, input logic [YS-1:0] p);
        logic [YS-1:0] s;
        s = {1'b0, y} + p;
        return s[YS-1] ? '1 : s[Y_W:0];
    endfunction

    // x + w - 1 > limit is rewritten as x + w > limit + 1 so size 0 is safe.
    // A glyph already at the left margin never wraps, even if too wide.
    always_comb begin
        x_over = ({1'b0, cursor_x_q} + glyph_w) > ({2'b0, limit_x_q} + XS'(1));
        wrap   = x_over && (cursor_x_q != {1'b0, base_x_q});
        x_chk  = wrap ? {1'b0, base_x_q} : cursor_x_q;
        y_chk  = wrap ? y_step(cursor_y_q, pitch_y) : cursor_y_q;
        y_over = ({1'b0, y_chk} + glyph_h) > ({2'b0, limit_y_q} + YS'(1));
    end

    always_comb begin
        state_d       = state_q;
        base_x_d      = base_x_q;
        base_y_d      = base_y_q;
        limit_x_d     = limit_x_q;
        limit_y_d     = limit_y_q;
        length_d      = length_q;
        index_d       = index_q;
        chars_drawn_d = chars_drawn_q;
        cursor_x_d    = cursor_x_q;
        cursor_y_d    = cursor_y_q;
        char_code_d   = char_code_q;
        origin_x_d    = origin_x_q;
        origin_y_d    = origin_y_q;
        char_size_d   = char_size_q;
        overflow_d    = overflow_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_x_d      = base_x;
                    base_y_d      = base_y;
                    limit_x_d     = limit_x;
                    limit_y_d     = limit_y;
                    length_d      = length;
                    char_size_d   = size;
                    index_d       = '0;
                    cursor_x_d    = {1'b0, base_x};
                    cursor_y_d    = {1'b0, base_y};
                    chars_drawn_d = '0;
                    overflow_d    = 1'b0;
                    state_d       = (length == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT:  state_d = S_CHECK;
            S_CHECK: begin
                char_code_d = str_data;
                if (str_data == '0) begin
                    state_d = S_DONE;
                end else if (str_data == CHAR_W'(8'h0A)) begin
                    cursor_x_d = {1'b0, base_x_q};
                    cursor_y_d = y_step(cursor_y_q, pitch_y);
                    index_d    = index_q + LEN_W'(1);
                    state_d    = S_NEXT;
                end else begin
                    cursor_x_d = x_chk;
                    cursor_y_d = y_chk;
                    if (y_over) begin
                        overflow_d = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        // Both checks passed, so the cursor fits the output widths.
                        origin_x_d = x_chk[X_W-1:0];
                        origin_y_d = y_chk[Y_W-1:0];
                        state_d    = S_LOAD;
                    end
                end
            end
            S_LOAD: state_d = S_RUN;
            S_RUN: begin
                if (char_finished) begin
                    chars_drawn_d = chars_drawn_q + LEN_W'(1);
                    cursor_x_d    = x_step(cursor_x_q, pitch_x);
                    index_d       = index_q + LEN_W'(1);
                    state_d       = S_NEXT;
                end
            end
            S_NEXT:  state_d = (index_q == length_q) ? S_DONE : S_FETCH;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        char_enable_d = (state_d == S_RUN);
        busy_d        = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d        = (state_q == S_DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            base_x_q      <= '0;
            base_y_q      <= '0;
            limit_x_q     <= '0;
            limit_y_q     <= '0;
            length_q      <= '0;
            index_q       <= '0;
            chars_drawn_q <= '0;
            cursor_x_q    <= '0;
            cursor_y_q    <= '0;
            char_code_q   <= '0;
            origin_x_q    <= '0;
            origin_y_q    <= '0;
            char_size_q   <= '0;
            char_enable_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            base_x_q      <= base_x_d;
            base_y_q      <= base_y_d;
            limit_x_q     <= limit_x_d;
            limit_y_q     <= limit_y_d;
            length_q      <= length_d;
            index_q       <= index_d;
            chars_drawn_q <= chars_drawn_d;
            cursor_x_q    <= cursor_x_d;
            cursor_y_q    <= cursor_y_d;
            char_code_q   <= char_code_d;
            origin_x_q    <= origin_x_d;
            origin_y_q    <= origin_y_d;
            char_size_q   <= char_size_d;
            char_enable_q <= char_enable_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            overflow_q    <= overflow_d;
        end
    end

    assign str_addr      = index_q;
    assign char_code     = char_code_q;
    assign char_origin_x = origin_x_q;
    assign char_origin_y = origin_y_q;
    assign char_size     = char_size_q;
    assign char_enable   = char_enable_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign overflow      = overflow_q;
    assign chars_drawn   = chars_drawn_q;

endmodule

// File: tb/tb_text_line_sequencer.sv
// tb/tb_text_line_sequencer.sv - directed self-checking bench for text_line_sequencer
module tb_text_line_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [8:0] base_x = 9'd10;
    logic [7:0] base_y = 8'd20;
    logic [3:0] size = 4'd2;
    logic [5:0] length = 6'd0;
    logic [8:0] limit_x = 9'd319;
    logic [7:0] limit_y = 8'd239;
    logic [5:0] str_addr;
    logic [6:0] str_data = 7'd0;
    logic [6:0] char_code;
    logic [8:0] char_origin_x;
    logic [7:0] char_origin_y;
    logic [3:0] char_size;
    logic       char_enable;
    logic       char_finished;
    logic       busy, done, overflow;
    logic [5:0] chars_drawn;

    always #5 clock = ~clock;

    text_line_sequencer dut (
        .clock(clock), .reset(reset), .start(start),
        .base_x(base_x), .base_y(base_y), .size(size), .length(length),
        .limit_x(limit_x), .limit_y(limit_y),
        .str_addr(str_addr), .str_data(str_data),
        .char_code(char_code), .char_origin_x(char_origin_x),
        .char_origin_y(char_origin_y), .char_size(char_size),
        .char_enable(char_enable), .char_finished(char_finished),
        .busy(busy), .done(done), .overflow(overflow), .chars_drawn(chars_drawn)
    );

    // String memory with one cycle of read latency.
    logic [6:0] mem [0:63];
    always @(posedge clock) str_data <= mem[str_addr];

    // Renderer model: finished rises after lat enabled cycles, sticky while enabled.
    int lat = 3;
    int rcnt = 0;
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            rcnt <= 0;
            char_finished <= 1'b0;
        end else if (!char_enable) begin
            rcnt <= 0;
            char_finished <= 1'b0;
        end else if (rcnt >= lat - 1) begin
            char_finished <= 1'b1;
        end else begin
            rcnt <= rcnt + 1;
        end
    end

    // Glyph log captured at each rising char_enable, plus the shortest low gap.
    logic [8:0] gx [$];
    logic [7:0] gy [$];
    logic [6:0] gc [$];
    bit prev_en = 1'b0;
    int low_run = 0;
    int min_gap = 1000;
    always @(negedge clock) begin
        if (char_enable && !prev_en) begin
            if (gx.size() > 0 && low_run < min_gap) min_gap = low_run;
            gx.push_back(char_origin_x);
            gy.push_back(char_origin_y);
            gc.push_back(char_code);
        end
        low_run = char_enable ? 0 : low_run + 1;
        prev_en = char_enable;
    end

    int checks = 0;
    int errors = 0;

    task automatic set_cfg(input logic [8:0] lx, input logic [7:0] ly);
        base_x  = 9'd10;
        base_y  = 8'd20;
        size    = 4'd2;
        limit_x = lx;
        limit_y = ly;
    endtask

    task automatic launch(input logic [5:0] len, output bit timed_out);
        int cyc;
        gx.delete(); gy.delete(); gc.delete();
        min_gap = 1000;
        length = len;
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 3000) begin
            @(negedge clock);
            cyc++;
        end
        timed_out = (done !== 1'b1);
    endtask

    task automatic test_reset();
        @(negedge clock);
        checks++;
        if ({str_addr, char_code, char_origin_x, char_origin_y, char_size,
             char_enable, busy, done, overflow, chars_drawn} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got nonzero outputs addr=%0d en=%b busy=%b done=%b expected all 0",
                     str_addr, char_enable, busy, done);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        bit to;
        set_cfg(9'd319, 8'd239);
        mem[0] = 7'h41; mem[1] = 7'h42; mem[2] = 7'h43;
        launch(6'd3, to);
        checks++;
        if (to) begin errors++; $display("FAIL basic_timeout: done not seen, expected done"); end
        checks++;
        if (gx.size() !== 3) begin
            errors++; $display("FAIL basic_glyph_count: got %0d expected 3", gx.size());
        end else begin
            checks++;
            if ({gx[0], gy[0], gx[1], gy[1], gx[2], gy[2]} !== {9'd10, 8'd20, 9'd22, 8'd20, 9'd34, 8'd20}) begin
                errors++;
                $display("FAIL basic_origins: got (%0d,%0d) (%0d,%0d) (%0d,%0d) expected (10,20) (22,20) (34,20)",
                         gx[0], gy[0], gx[1], gy[1], gx[2], gy[2]);
            end
            checks++;
            if ({gc[0], gc[1], gc[2]} !== {7'h41, 7'h42, 7'h43}) begin
                errors++; $display("FAIL basic_codes: got %h %h %h expected 41 42 43", gc[0], gc[1], gc[2]);
            end
        end
        checks++;
        if (chars_drawn !== 6'd3 || overflow !== 1'b0 || char_size !== 4'd2) begin
            errors++;
            $display("FAIL basic_status: got drawn=%0d ovf=%b size=%0d expected drawn=3 ovf=0 size=2",
                     chars_drawn, overflow, char_size);
        end
    endtask

    task automatic test_wrap();
        bit to;
        set_cfg(9'd40, 8'd239);
        mem[0] = 7'h41; mem[1] = 7'h42; mem[2] = 7'h43; mem[3] = 7'h44;
        launch(6'd4, to);
        checks++;
        if (to || gx.size() !== 4) begin
            errors++; $display("FAIL wrap_count: got %0d glyphs timeout=%b expected 4", gx.size(), to);
        end else begin
            checks++;
            if ({gx[2], gy[2], gx[3], gy[3]} !== {9'd10, 8'd36, 9'd22, 8'd36}) begin
                errors++;
                $display("FAIL wrap_origins: got C(%0d,%0d) D(%0d,%0d) expected C(10,36) D(22,36)",
                         gx[2], gy[2], gx[3], gy[3]);
            end
        end
        checks++;
        if (chars_drawn !== 6'd4 || overflow !== 1'b0) begin
            errors++; $display("FAIL wrap_status: got drawn=%0d ovf=%b expected 4 0", chars_drawn, overflow);
        end
    endtask

    task automatic test_overflow();
        bit to;
        set_cfg(9'd40, 8'd40);
        mem[0] = 7'h41; mem[1] = 7'h42; mem[2] = 7'h43; mem[3] = 7'h44;
        launch(6'd4, to);
        checks++;
        if (to) begin errors++; $display("FAIL ovf_timeout: done not seen, expected done"); end
        checks++;
        if (gx.size() !== 2) begin
            errors++; $display("FAIL ovf_glyph_count: got %0d expected 2", gx.size());
        end
        checks++;
        if (chars_drawn !== 6'd2 || overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_status: got drawn=%0d ovf=%b expected 2 1", chars_drawn, overflow);
        end
    endtask

    task automatic test_control_codes();
        bit to;
        set_cfg(9'd319, 8'd239);
        mem[0] = 7'h41; mem[1] = 7'h0A; mem[2] = 7'h42; mem[3] = 7'h00; mem[4] = 7'h43;
        launch(6'd5, to);
        checks++;
        if (to || gx.size() !== 2) begin
            errors++; $display("FAIL ctrl_count: got %0d glyphs timeout=%b expected 2", gx.size(), to);
        end else begin
            checks++;
            if ({gx[0], gy[0], gx[1], gy[1]} !== {9'd10, 8'd20, 9'd10, 8'd36}) begin
                errors++;
                $display("FAIL ctrl_origins: got A(%0d,%0d) B(%0d,%0d) expected A(10,20) B(10,36)",
                         gx[0], gy[0], gx[1], gy[1]);
            end
        end
        checks++;
        if (chars_drawn !== 6'd2 || overflow !== 1'b0) begin
            errors++; $display("FAIL ctrl_status: got drawn=%0d ovf=%b expected 2 0", chars_drawn, overflow);
        end
    endtask

    task automatic test_handshake();
        int cyc;
        set_cfg(9'd319, 8'd239);
        lat = 30;
        mem[0] = 7'h41; mem[1] = 7'h42;
        gx.delete(); gy.delete(); gc.delete();
        min_gap = 1000;
        length = 6'd2;
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
        repeat (10) @(negedge clock);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL hs_busy: got %b expected 1", busy); end
        // A second start while busy must be ignored.
        length = 6'd1;
        start = 1'b1;
        @(negedge clock); start = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 3000) begin @(negedge clock); cyc++; end
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL hs_timeout: done not seen, expected done"); end
        checks++;
        if (gx.size() !== 2 || chars_drawn !== 6'd2) begin
            errors++; $display("FAIL hs_count: got glyphs=%0d drawn=%0d expected 2 2", gx.size(), chars_drawn);
        end
        checks++;
        if (min_gap < 2) begin errors++; $display("FAIL hs_low_gap: got %0d expected at least 2", min_gap); end
        repeat (6) @(negedge clock);
        checks++;
        if (busy !== 1'b0 || gx.size() !== 2) begin
            errors++; $display("FAIL hs_no_restart: got busy=%b glyphs=%0d expected 0 2", busy, gx.size());
        end
        lat = 3;
    endtask

    task automatic test_zero_length();
        length = 6'd0;
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL zero_cycle1: got done=%b busy=%b expected 0 0", done, busy);
        end
        @(negedge clock);
        checks++;
        if (done !== 1'b1 || chars_drawn !== 6'd0) begin
            errors++; $display("FAIL zero_cycle2: got done=%b drawn=%0d expected 1 0", done, chars_drawn);
        end
        @(negedge clock);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL zero_pulse: got done=%b expected 0", done); end
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        bit to;
        set_cfg(9'd319, 8'd239);
        lat = 30;
        mem[0] = 7'h41; mem[1] = 7'h42; mem[2] = 7'h43;
        length = 6'd3;
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
        cyc = 0;
        while (char_enable !== 1'b1 && cyc < 50) begin @(negedge clock); cyc++; end
        checks++;
        if (char_enable !== 1'b1) begin errors++; $display("FAIL rst_run_reached: got en=%b expected 1", char_enable); end
        repeat (3) @(negedge clock);
        reset = 1'b1;
        #1;
        checks++;
        if ({str_addr, char_code, char_origin_x, char_origin_y, char_size,
             char_enable, busy, done, overflow, chars_drawn} !== '0) begin
            errors++;
            $display("FAIL rst_mid_run: got en=%b busy=%b code=%h x=%0d expected all 0",
                     char_enable, busy, char_code, char_origin_x);
        end
        @(negedge clock);
        reset = 1'b0;
        lat = 3;
        launch(6'd3, to);
        checks++;
        if (to || chars_drawn !== 6'd3 || gx.size() !== 3) begin
            errors++;
            $display("FAIL rst_rerun: got drawn=%0d glyphs=%0d timeout=%b expected 3 3 0",
                     chars_drawn, gx.size(), to);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 7'h00;
        test_reset();
        test_basic();
        test_wrap();
        test_overflow();
        test_control_codes();
        test_handshake();
        test_zero_length();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
